// File: rtl/pic_pkg.sv
// Shared OCW2 command codes, widths and priority helper for the PIC priority resolver.
package pic_pkg;

  localparam int unsigned IR_W  = 8;
  localparam int unsigned LVL_W = 3;

  // OCW2 command field {R,SL,EOI}
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NSEOI        = 3'b001;
  localparam logic [2:0] OCW2_SEOI         = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NSEOI    = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SEOI     = 3'b111;

  localparam logic [2:0] LOWEST_RESET = 3'd7;

  // Priority rank of a level relative to the current lowest; 0 is highest.
  function automatic logic [2:0] pri_of(input logic [2:0] level, input logic [2:0] lowest);
    return 3'(level - lowest - 3'd1);
  endfunction

endpackage

// File: rtl/pic_priority_encoder.sv
// Rotating priority encoder: picks the highest-priority set bit of req given the lowest level.
module pic_priority_encoder
  import pic_pkg::*;
(
  input  logic [IR_W-1:0]  req,
  input  logic [LVL_W-1:0] lowest,
  output logic             valid,
  output logic [LVL_W-1:0] level
);

  logic [LVL_W-1:0] idx;

  // Scan from lowest priority upward so the highest-priority hit is written last.
  always_comb begin
    valid = 1'b0;
    level = '0;
    idx   = '0;
    for (int i = int'(IR_W) - 1; i >= 0; i--) begin
      idx = LVL_W'(lowest + LVL_W'(i) + LVL_W'(1));
      if (req[idx]) begin
        valid = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/pic_priority_resolver.sv
// IRR/ISR and fully nested priority resolution stage of the 8259A PIC.
// Define PIC_ROTATE_EN to add the rotating-priority register and rotate-in-AEOI flag.
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IR = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] IR,
  input  logic [NUM_IR-1:0] IMR,
  input  logic              LTIM,
  input  logic              AEOI,
  input  logic              ocw2_wr,
  input  logic [7:0]        OCW2,
  input  logic              first_ACK,
  input  logic              second_ACK,
  output logic              INT,
  output logic [2:0]        INT_VEC,
  output logic [NUM_IR-1:0] IRR,
  output logic [NUM_IR-1:0] ISR
);

  logic [NUM_IR-1:0] ir_q, ir_d;
  logic [NUM_IR-1:0] irr_q, irr_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic              int_q, int_d;
  logic [2:0]        int_vec_q, int_vec_d;
  logic              ack1_q, ack1_d;
  logic              ack2_q, ack2_d;
  logic [2:0]        lowest;

`ifdef PIC_ROTATE_EN
  logic [2:0] lowest_q, lowest_d;
  logic       rot_aeoi_q, rot_aeoi_d;
  assign lowest = lowest_q;
`else
  assign lowest = LOWEST_RESET;
`endif

  logic [NUM_IR-1:0] cand;
  logic              pend_valid, srv_valid;
  logic [2:0]        pend, srv;
  logic [2:0]        ocw2_cmd, ocw2_l;
  logic              first_rise, second_rise;
  logic              unused_ocw2;

  assign cand        = irr_q & ~IMR;
  assign ocw2_cmd    = OCW2[7:5];
  assign ocw2_l      = OCW2[2:0];
  assign unused_ocw2 = ^OCW2[4:3];
  assign first_rise  = first_ACK & ~ack1_q;
  assign second_rise = second_ACK & ~ack2_q;

  pic_priority_encoder u_pend_enc (
    .req    (cand),
    .lowest (lowest),
    .valid  (pend_valid),
    .level  (pend)
  );

  pic_priority_encoder u_srv_enc (
    .req    (isr_q),
    .lowest (lowest),
    .valid  (srv_valid),
    .level  (srv)
  );

  // Next-state: OCW2 clears first, then AEOI, then the ACK set so a same-cycle set wins.
  always_comb begin
    ir_d      = IR;
    ack1_d    = first_ACK;
    ack2_d    = second_ACK;
    irr_d     = LTIM ? IR : (irr_q | (IR & ~ir_q));
    isr_d     = isr_q;
    int_vec_d = int_vec_q;
    int_d     = pend_valid && (!srv_valid || (pri_of(pend, lowest) < pri_of(srv, lowest)));
`ifdef PIC_ROTATE_EN
    lowest_d   = lowest_q;
    rot_aeoi_d = rot_aeoi_q;
`endif

    if (ocw2_wr) begin
      case (ocw2_cmd)
        OCW2_NSEOI, OCW2_ROT_NSEOI: begin
          if (srv_valid) begin
            isr_d[srv] = 1'b0;
`ifdef PIC_ROTATE_EN
            if (ocw2_cmd == OCW2_ROT_NSEOI) lowest_d = srv;
`endif
          end
        end
        OCW2_SEOI, OCW2_ROT_SEOI: begin
          isr_d[ocw2_l] = 1'b0;
`ifdef PIC_ROTATE_EN
          if (ocw2_cmd == OCW2_ROT_SEOI) lowest_d = ocw2_l;
`endif
        end
`ifdef PIC_ROTATE_EN
        OCW2_SET_PRI:      lowest_d   = ocw2_l;
        OCW2_ROT_AEOI_SET: rot_aeoi_d = 1'b1;
        OCW2_ROT_AEOI_CLR: rot_aeoi_d = 1'b0;
`endif
        default: begin
        end
      endcase
    end

    if (second_rise && AEOI) begin
      isr_d[int_vec_q] = 1'b0;
`ifdef PIC_ROTATE_EN
      if (rot_aeoi_q) lowest_d = int_vec_q;
`endif
    end

    if (first_rise) begin
      int_d = 1'b0;
      if (pend_valid) begin
        int_vec_d   = pend;
        isr_d[pend] = 1'b1;
        if (!LTIM) irr_d[pend] = 1'b0;
      end else begin
        int_vec_d = 3'd7;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q      <= '0;
      irr_q     <= '0;
      isr_q     <= '0;
      int_q     <= 1'b0;
      int_vec_q <= 3'd0;
      ack1_q    <= 1'b0;
      ack2_q    <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      int_q     <= int_d;
      int_vec_q <= int_vec_d;
      ack1_q    <= ack1_d;
      ack2_q    <= ack2_d;
    end
  end

`ifdef PIC_ROTATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lowest_q   <= LOWEST_RESET;
      rot_aeoi_q <= 1'b0;
    end else begin
      lowest_q   <= lowest_d;
      rot_aeoi_q <= rot_aeoi_d;
    end
  end
`endif

  assign INT     = int_q;
  assign INT_VEC = int_vec_q;
  assign IRR     = irr_q;
  assign ISR     = isr_q;

endmodule
